// File: rtl/param_pio_ctrl.sv
// Avalon-MM parallel I/O controller: per-bit direction, atomic set/clear,
// synchronised inputs with edge capture and a maskable level interrupt.
module param_pio_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [31:0] OUT_RESET   = '0,
  parameter logic [31:0] DIR_RESET   = '0,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_MASK    = 3'd2,
    REG_EDGECAP = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_addr_e;

  // Registers are held 32 bits wide with the bits above DATA_WIDTH forced to
  // zero; those constant flops vanish in synthesis.
  localparam logic [31:0] WMASK = (32'd1 << DATA_WIDTH) - 32'd1;

  logic [31:0] out_q, out_d;
  logic [31:0] dir_q, dir_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] edgecap_q, edgecap_d;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q, irq_d;
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_q, prev_d;

  logic        wr_en, rd_en;
  logic [31:0] wdata, in_ext, prev_ext, edge_raw, edge_det, ec_clr, rd_val;
  reg_addr_e   reg_addr;

  always_comb begin
    wr_en    = chipselect & ~write_n;
    rd_en    = chipselect & ~read_n;
    reg_addr = reg_addr_e'(address);
    wdata    = writedata & WMASK;

    in_ext   = '0;
    prev_ext = '0;
    in_ext[DATA_WIDTH-1:0]   = sync_q[SYNC_STAGES-1];
    prev_ext[DATA_WIDTH-1:0] = prev_q;

    case (EDGE_TYPE)
      0:       edge_raw = in_ext & ~prev_ext;
      1:       edge_raw = ~in_ext & prev_ext;
      default: edge_raw = in_ext ^ prev_ext;
    endcase
    edge_det = edge_raw & ~dir_q & WMASK;

    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    ec_clr = '0;
    if (wr_en) begin
      case (reg_addr)
        REG_DATA:    out_d  = wdata;
        REG_DIR:     dir_d  = wdata;
        REG_MASK:    mask_d = wdata;
        REG_EDGECAP: ec_clr = wdata;
        REG_OUTSET:  out_d  = out_q | wdata;
        REG_OUTCLR:  out_d  = out_q & ~wdata;
        default:     ;
      endcase
    end

    // OR-ing the new edge after the clear lets a same-cycle edge win.
    edgecap_d = (edgecap_q & ~ec_clr) | edge_det;
    irq_d     = |(edgecap_q & mask_q);

    case (reg_addr)
      REG_DATA:    rd_val = (dir_q & out_q) | (~dir_q & in_ext);
      REG_DIR:     rd_val = dir_q;
      REG_MASK:    rd_val = mask_q;
      REG_EDGECAP: rd_val = edgecap_q;
      default:     rd_val = '0;
    endcase
    readdata_d = rd_en ? (rd_val & WMASK) : readdata_q;

    sync_d[0] = in_port;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= OUT_RESET & WMASK;
      dir_q      <= DIR_RESET & WMASK;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      prev_q     <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      prev_q     <= prev_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_q[DATA_WIDTH-1:0];
  assign oe_port  = dir_q[DATA_WIDTH-1:0];
  assign irq      = irq_q;

endmodule

// File: tb/tb_param_pio_ctrl.sv
// Directed bench for param_pio_ctrl: vector table for register behaviour plus
// hand sequences for edge capture, interrupt timing and asynchronous reset.
module tb_param_pio_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe_port;
  logic        irq;

  int n_checks;
  int n_fail;

  param_pio_ctrl #(
    .DATA_WIDTH (8),
    .OUT_RESET  (32'hA5),
    .DIR_RESET  (32'hFF),
    .EDGE_TYPE  (0),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .read_n    (read_n),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .oe_port   (oe_port),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  inp;
    logic [7:0]  eout;
    logic [7:0]  eoe;
    logic [31:0] erd;
    logic        eirq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    read_n     = ~rd;
    write_n    = ~wr;
    address    = a;
    writedata  = d;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    tick();
    idle();
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    drive(1'b1, 1'b0, a, '0);
    tick();
    idle();
    check(name, readdata, exp);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    address  = '0;
    in_port  = '0;
    idle();

    //                 rd    wr    addr  wdata         inp    out    oe     rd_exp        irq
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,        8'h00, 8'hA5, 8'hFF, 32'h000000A5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd4, 32'h0F,       8'h00, 8'hAF, 8'hFF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd5, 32'h81,       8'h00, 8'h2E, 8'hFF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd0, 32'hFFFFFF00, 8'h00, 8'h00, 8'hFF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0,        8'h00, 8'h00, 8'hFF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd0, 32'h50,       8'h00, 8'h50, 8'hFF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd1, 32'hF0,       8'h00, 8'h50, 8'hF0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,        8'h3C, 8'h50, 8'hF0, 32'h50,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,        8'h3C, 8'h50, 8'hF0, 32'h50,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,        8'h3C, 8'h50, 8'hF0, 32'h5C,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h0,        8'h3C, 8'h50, 8'hF0, 32'h0C,       1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h00,       8'h3C, 8'h50, 8'h00, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h3C,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h00,       1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 32'h04,       8'h3C, 8'h50, 8'h00, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h08,       1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 32'h00,       8'h3C, 8'h50, 8'h00, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h08,       1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 32'h08,       8'h3C, 8'h50, 8'h00, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h00,       1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd2, 32'hFFFFFF03, 8'h3C, 8'h50, 8'h00, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h03,       1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd6, 32'hFF,       8'h3C, 8'h50, 8'h00, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd6, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h00,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd7, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h00,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h00,       1'b0});
    // Simultaneous read and write of MASK: read sees the old value.
    vecs.push_back('{1'b1, 1'b1, 3'd2, 32'h01,       8'h3C, 8'h50, 8'h00, 32'h03,       1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h0,        8'h3C, 8'h50, 8'h00, 32'h01,       1'b0});

    #12;
    check("reset out_port", 32'(out_port), 32'hA5);
    check("reset oe_port", 32'(oe_port), 32'hFF);
    check("reset irq", 32'(irq), 32'h0);
    check("reset readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_port = vecs[i].inp;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      tick();
      idle();
      check($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].eout));
      check($sformatf("vec%0d oe_port", i), 32'(oe_port), 32'(vecs[i].eoe));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].eirq));
      if (vecs[i].rd) check($sformatf("vec%0d readdata", i), readdata, vecs[i].erd);
    end

    // Rising edge on bit0 with MASK=0x01: capture at edge 3, irq at edge 4.
    in_port = 8'h3D;
    wait_n(3);
    check("A irq before capture", 32'(irq), 32'h0);
    tick();
    check("A irq after capture", 32'(irq), 32'h1);
    do_read(3'd3, 32'h01, "A edgecap set");
    do_write(3'd3, 32'h00);
    do_read(3'd3, 32'h01, "A edgecap w0 no effect");
    check("A irq held", 32'(irq), 32'h1);
    do_write(3'd3, 32'h01);
    check("A irq one cycle after clear", 32'(irq), 32'h1);
    tick();
    check("A irq deasserted", 32'(irq), 32'h0);
    do_read(3'd3, 32'h00, "A edgecap cleared");

    // Re-capture bit0, then an edge coinciding with its clear must win.
    in_port = 8'h3C;
    wait_n(4);
    in_port = 8'h3D;
    wait_n(4);
    check("B irq set", 32'(irq), 32'h1);
    in_port = 8'h3C;
    wait_n(4);
    check("B irq after falling", 32'(irq), 32'h1);
    in_port = 8'h3D;
    tick();
    tick();
    drive(1'b0, 1'b1, 3'd3, 32'h01);
    tick();
    idle();
    check("B irq at collision", 32'(irq), 32'h1);
    tick();
    check("B irq after collision", 32'(irq), 32'h1);
    do_read(3'd3, 32'h01, "B edge wins");

    // Fill edgecap with all bits, then reset asynchronously mid-read.
    do_write(3'd2, 32'hFF);
    in_port = 8'h00;
    wait_n(4);
    in_port = 8'hFF;
    wait_n(4);
    do_read(3'd3, 32'hFF, "C edgecap all");
    check("C irq before reset", 32'(irq), 32'h1);
    drive(1'b1, 1'b0, 3'd3, '0);
    #2;
    reset_n = 1'b0;
    #1;
    check("C async readdata", readdata, 32'h0);
    check("C async irq", 32'(irq), 32'h0);
    check("C async out_port", 32'(out_port), 32'hA5);
    check("C async oe_port", 32'(oe_port), 32'hFF);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    do_read(3'd3, 32'h00, "C edgecap after reset");
    do_read(3'd2, 32'h00, "C mask after reset");
    check("C irq after reset", 32'(irq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_pio_ctrl.md
Name: param_pio_ctrl

Overview:
- Parametrised Avalon-MM parallel I/O controller; next-generation general-purpose PIO for HPS/FPGA control and status lines (resets, LEDs, switches, handshake flags).
- Adds per-bit direction, atomic set/clear, synchronised inputs, edge capture and a maskable interrupt.
- Sits on the lightweight bridge as a slave; one instance per I/O group.

Parameters:
- DATA_WIDTH, 8, number of I/O bits (1..32).
- OUT_RESET, 0, reset value of the output data register (low DATA_WIDTH bits used).
- DIR_RESET, 0, reset value of the direction register (1 = output).
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, input synchroniser depth (2..3).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, valid 1 cycle after the read strobe.
- in_port  in  DATA_WIDTH  asynchronous input pins.
- out_port  out  DATA_WIDTH  output data register.
- oe_port  out  DATA_WIDTH  per-bit output enable (equals the direction register).
- irq  out  1  level interrupt.

Behaviour:
- Clocking and reset: one clock domain. reset_n is asynchronous and active-low and clears all state immediately.
- Reset values: out_port = OUT_RESET, oe_port = DIR_RESET, mask = 0, edgecap = 0, readdata = 0, synchroniser and edge-history flops = 0, irq = 0.
- Register map. Access occurs when chipselect is 1 and the corresponding strobe is low.
  - 0 DATA. Write: out_reg = writedata. Read: (dir & out_reg) | (~dir & in_sync).
  - 1 DIR. Read/write.
  - 2 MASK. Read/write.
  - 3 EDGECAP. Read returns captured bits. Writing 1 to a bit clears it; writing 0 has no effect.
  - 4 OUTSET. Write: out_reg |= writedata. Reads return 0.
  - 5 OUTCLR. Write: out_reg &= ~writedata. Reads return 0.
  - 6, 7: reserved. Writes are ignored; reads return 0.
- Width rules:
  - Bits at or above DATA_WIDTH are ignored on write and read as 0.
  - readdata is zero-extended to 32 bits.
- Read latency:
  - readdata is registered and updates on the clock edge after the read strobe.
  - readdata holds its value when no read is in progress.
  - A read and a write in the same cycle: the write takes effect and the read returns the pre-write value.
- Input path:
  - in_port passes through a SYNC_STAGES flop chain to produce in_sync.
  - A prev register holds in_sync from the previous cycle.
  - A change at in_port appears in in_sync after SYNC_STAGES edges and in edgecap one edge later.
- Edge detection, per bit, enabled only where dir = 0:
  - rising: in_sync & ~prev
  - falling: ~in_sync & prev
  - any: in_sync ^ prev
- Edge-capture boundary conditions:
  - A detected edge sets its capture bit; the bit stays set until cleared by software.
  - An edge and a write-1-to-clear on the same bit in the same cycle: the edge wins and the bit stays 1.
  - Output bits (dir = 1) never set capture bits. Changing a bit to an output does not clear an existing capture.
- irq = |(edgecap & mask), registered. It asserts 1 cycle after the capture bit or mask bit becomes 1 and deasserts 1 cycle after the clear.
- out_port and oe_port drive directly from their registers: 0 cycles after the write edge, no glitches.
- Reset mid-operation: all state returns to the reset values above within the same cycle. No pending read or write survives the reset.

Test Plan:
- Reset with DATA_WIDTH=8, OUT_RESET=0xA5, DIR_RESET=0xFF -> out_port=0xA5, oe_port=0xFF, irq=0; a read of address 0 returns 0x000000A5 one cycle later.
- Write 0x0F to address 4, then 0x81 to address 5, starting from out=0xA5 -> out_port=0xAF, then 0x2E; a write of 0xFFFFFF00 to address 0 gives out_port=0x00.
- DIR=0x00, in_port=0x3C held -> an address 0 read returns 0x3C only from the (SYNC_STAGES+1)th cycle onward; DIR=0xF0 with out=0x50 reads 0x5C.
- EDGE_TYPE=0, MASK=0x01, in_port bit0 pulsed 0->1 -> edgecap=0x01 at edge SYNC_STAGES+1 and irq=1 one cycle later. Writing 0x01 to address 3 clears both; writing 0x00 does not.
- Rising edge on bit0 in the same cycle as a write of 0x01 to address 3 -> edgecap bit0 stays 1 and irq stays 1.
- Assert reset_n low mid-read while edgecap=0xFF and irq=1 -> readdata, edgecap and irq are 0 immediately, with no clock edge required.
